// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Instruction-fetch port and datapath control bundle driven by
//               instr_sequencer. The master side is the sequencer. The slave
//               side is the instruction memory and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 16
);
  // instruction fetch handshake
  logic                  I_REQ;
  logic [PC_WIDTH-1:0]   I_ADDR;
  logic [DATA_WIDTH-1:0] I_DATA;
  logic                  I_VALID;
  // datapath control fields
  logic [21:0]           OSD;
  logic [1:0]            SEL;
  logic [DATA_WIDTH-1:0] A_IMM;
  logic [DATA_WIDTH-1:0] B_IMM;
  logic [DATA_WIDTH-1:0] ADDR;
  logic                  X;
  logic                  Y;
  logic                  R_W;
  logic [5:0]            W_INST;
  logic [5:0]            R_INST;

  modport master (
    output I_REQ, I_ADDR, OSD, SEL, A_IMM, B_IMM, ADDR, X, Y, R_W, W_INST, R_INST,
    input  I_DATA, I_VALID
  );

  modport slave (
    input  I_REQ, I_ADDR, OSD, SEL, A_IMM, B_IMM, ADDR, X, Y, R_W, W_INST, R_INST,
    output I_DATA, I_VALID
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetches instruction words over a request/valid port. It
//               decodes each word into registered datapath control fields.
//               It sequences extension-word fetches and the delayed writeback
//               of loads.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         MEM_LAT    = 2,
  parameter logic [5:0]          WB_ALU     = 6'h01,
  parameter logic [5:0]          WB_MEM     = 6'h02,
  parameter logic [5:0]          RD_STORE   = 6'h01
) (
  input  wire logic          CLK,
  input  wire logic          RST_N,
  input  wire logic          START,
  instr_sequencer_if.master  bus,
  output logic               BUSY,
  output logic               HALTED
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXT1    = 3'd2,
    S_EXT2    = 3'd3,
    S_ISSUE   = 3'd4,
    S_MEMWAIT = 3'd5,
    S_WB      = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [1:0] CL_ALU   = 2'b00;
  localparam logic [1:0] CL_LOAD  = 2'b01;
  localparam logic [1:0] CL_STORE = 2'b10;
  localparam logic [1:0] CL_HALT  = 2'b11;

  localparam logic [3:0]          LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;   // opcode word of the instruction in flight
  logic [DATA_WIDTH-1:0] ext1_q, ext1_d;     // first extension word (A of a sel=3 pair)
  logic [3:0]            cnt_q, cnt_d;       // remaining MEMWAIT cycles
  logic                  req_q, req_d;
  logic [21:0]           osd_q, osd_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  x_q, x_d;
  logic                  y_q, y_d;
  logic                  rw_q, rw_d;
  logic [5:0]            winst_q, winst_d;
  logic [5:0]            rinst_q, rinst_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;

  logic w_fetching;
  logic w_accept;

  // A word is consumed only while a fetch state is holding I_REQ high
  assign w_fetching = (state_q == S_FETCH) || (state_q == S_EXT1) || (state_q == S_EXT2);
  assign w_accept   = w_fetching && bus.I_VALID;

  // Next-state sequencing and the control fields for the state being entered
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ext1_d  = ext1_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    addr_d  = addr_q;
    osd_d   = '0;
    sel_d   = '0;
    x_d     = 1'b0;
    y_d     = 1'b0;
    rw_d    = 1'b0;
    winst_d = '0;
    rinst_d = '0;

    if (w_accept) begin
      pc_d = pc_q + PC_ONE;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (START) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (w_accept) begin
          instr_d = bus.I_DATA;
          case (bus.I_DATA[31:30])
            CL_ALU:  state_d = (bus.I_DATA[25:24] == 2'd0) ? S_ISSUE : S_EXT1;
            CL_HALT: state_d = S_HALT;
            default: state_d = S_EXT1;
          endcase
        end
      end
      S_EXT1: begin
        if (w_accept) begin
          ext1_d  = bus.I_DATA;
          state_d = ((instr_q[31:30] == CL_ALU) && (instr_q[25:24] == 2'd3)) ? S_EXT2 : S_ISSUE;
        end
      end
      S_EXT2: begin
        if (w_accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_q[31:30] == CL_LOAD) begin
          state_d = S_MEMWAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        if (cnt_q == 4'd0) state_d = S_WB;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // ISSUE is only entered on an accepted word, so I_DATA holds the last
    // extension word. The operand fields are loaded at that point.
    if (state_d == S_ISSUE) begin
      case (instr_d[31:30])
        CL_ALU: begin
          osd_d   = {instr_d[29:26], instr_d[23:18], instr_d[17:12], instr_d[11:6]};
          sel_d   = instr_d[25:24];
          winst_d = instr_d[0] ? WB_ALU : 6'd0;
          case (instr_d[25:24])
            2'd1: b_d = bus.I_DATA;
            2'd2: a_d = bus.I_DATA;
            2'd3: begin
              a_d = ext1_q;
              b_d = bus.I_DATA;
            end
            default: ;
          endcase
        end
        CL_LOAD: begin
          osd_d  = {16'd0, instr_d[28:23]};
          x_d    = ~instr_d[29];
          y_d    = instr_d[29];
          rw_d   = 1'b1;
          addr_d = bus.I_DATA;
        end
        CL_STORE: begin
          osd_d   = {4'd0, instr_d[28:23], 12'd0};
          x_d     = ~instr_d[29];
          y_d     = instr_d[29];
          rinst_d = RD_STORE;
          addr_d  = bus.I_DATA;
        end
        default: ;
      endcase
    end else if (state_d == S_WB) begin
      osd_d   = {16'd0, instr_q[28:23]};
      winst_d = WB_MEM;
    end

    req_d    = (state_d == S_FETCH) || (state_d == S_EXT1) || (state_d == S_EXT2);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // State and output registers; reset aborts any fetch or pending writeback
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ext1_q   <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      osd_q    <= '0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      rw_q     <= 1'b0;
      winst_q  <= '0;
      rinst_q  <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ext1_q   <= ext1_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      osd_q    <= osd_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rw_q     <= rw_d;
      winst_q  <= winst_d;
      rinst_q  <= rinst_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign bus.I_REQ  = req_q;
  assign bus.I_ADDR = pc_q;
  assign bus.OSD    = osd_q;
  assign bus.SEL    = sel_q;
  assign bus.A_IMM  = a_q;
  assign bus.B_IMM  = b_q;
  assign bus.ADDR   = addr_q;
  assign bus.X      = x_q;
  assign bus.Y      = y_q;
  assign bus.R_W    = rw_q;
  assign bus.W_INST = winst_q;
  assign bus.R_INST = rinst_q;
  assign BUSY       = busy_q;
  assign HALTED     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Randomized self-checking bench for instr_sequencer. It builds
//               random programs and derives the expected fetch addresses and
//               control records from the instruction semantics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
  localparam int DW  = 32;
  localparam int PW  = 16;
  localparam int LAT = 2;

  logic CLK    = 1'b0;
  logic RST_N  = 1'b0;
  logic START  = 1'b0;
  logic START2 = 1'b0;
  logic BUSY, HALTED, BUSY2, HALTED2;

  instr_sequencer_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();
  instr_sequencer_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus2 ();

  instr_sequencer #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .RESET_PC(16'h0000), .MEM_LAT(LAT)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .bus(bus), .BUSY(BUSY), .HALTED(HALTED));

  instr_sequencer #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .RESET_PC(16'hFFFF), .MEM_LAT(LAT)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .START(START2), .bus(bus2), .BUSY(BUSY2), .HALTED(HALTED2));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One expected non-idle output cycle
  typedef struct packed {
    logic [21:0] osd;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] addr;
    logic        x;
    logic        y;
    logic        rw;
    logic [5:0]  winst;
    logic [5:0]  rinst;
    logic        ck_a;
    logic        ck_b;
    logic        ck_addr;
    logic        is_wb;
    logic        to_fetch;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] addr_q[$];
  bit [31:0]   imem[int];
  logic [15:0] gen_pc;

  task automatic put(input logic [31:0] w);
    imem[int'(gen_pc)] = w;
    addr_q.push_back(gen_pc);
    gen_pc = gen_pc + 16'd1;
  endtask

  // Random program segment terminated by HALT, plus its expected behaviour
  task automatic gen_segment(input int n);
    for (int k = 0; k < n; k++) begin
      int unsigned cls;
      logic [31:0] ea, eb, ad;
      logic [3:0]  opc;
      logic [1:0]  sel;
      logic [5:0]  sa, sb, des;
      logic        wb, bank;
      rec_t        r;
      cls  = $urandom_range(0, 2);
      ea   = $urandom;  eb = $urandom;  ad = $urandom;
      opc  = 4'($urandom); sel = 2'($urandom);
      sa   = 6'($urandom); sb  = 6'($urandom); des = 6'($urandom);
      wb   = 1'($urandom); bank = 1'($urandom);
      r    = '0;
      if (cls == 0) begin
        if ({opc, sa, sb, des} == 22'd0 && sel == 2'd0 && !wb) des = 6'd1;
        put({2'b00, opc, sel, sa, sb, des, 5'($urandom), wb});
        r.osd = {opc, sa, sb, des};
        r.sel = sel;
        r.winst = wb ? 6'h01 : 6'h00;
        r.to_fetch = 1'b1;
        if (sel[1]) begin put(ea); r.a = ea; r.ck_a = 1'b1; end
        if (sel[0]) begin put(eb); r.b = eb; r.ck_b = 1'b1; end
        exp_q.push_back(r);
      end else if (cls == 1) begin
        put({2'b01, bank, des, 23'($urandom)});
        put(ad);
        r.osd = {16'd0, des};
        r.x = ~bank; r.y = bank; r.rw = 1'b1;
        r.addr = ad; r.ck_addr = 1'b1;
        exp_q.push_back(r);
        r = '0;
        r.osd = {16'd0, des};
        r.winst = 6'h02;
        r.is_wb = 1'b1;
        r.to_fetch = 1'b1;
        exp_q.push_back(r);
      end else begin
        put({2'b10, bank, des, 23'($urandom)});
        put(ad);
        r.osd = {4'd0, des, 12'd0};
        r.x = ~bank; r.y = bank; r.rw = 1'b0;
        r.rinst = 6'h01;
        r.addr = ad; r.ck_addr = 1'b1;
        r.to_fetch = 1'b1;
        exp_q.push_back(r);
      end
    end
    put({2'b11, 30'($urandom)});
  endtask

  // Monitor and memory responder state
  bit          mon_en = 1'b0;
  bit          go = 1'b0;
  bit          pend_wait = 1'b0;
  bit          req_next = 1'b0;
  logic [15:0] pend_addr;
  int          cyc = 0;
  int          last_acc = -10;
  int          idle_run = 0;

  initial begin : p_mon
    rec_t e;
    bit   v, nonidle;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cyc++;
        if (pend_wait) begin
          chk("req_hold", bus.I_REQ, 1);
          chk("addr_hold", bus.I_ADDR, pend_addr);
        end
        if (req_next) begin
          chk("req_after_issue", bus.I_REQ, 1);
          req_next = 1'b0;
        end
        nonidle = (bus.OSD != 0) || (bus.SEL != 0) || bus.X || bus.Y ||
                  (bus.W_INST != 0) || (bus.R_INST != 0);
        if (nonidle) begin
          chk("xy_excl", bus.X & bus.Y, 0);
          chk("wr_excl", (|bus.W_INST) & (|bus.R_INST), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("osd", bus.OSD, e.osd);
            chk("sel", bus.SEL, e.sel);
            chk("w_inst", bus.W_INST, e.winst);
            chk("r_inst", bus.R_INST, e.rinst);
            chk("xy", {bus.X, bus.Y}, {e.x, e.y});
            if (e.ck_addr) begin
              chk("addr", bus.ADDR, e.addr);
              chk("r_w", bus.R_W, e.rw);
            end
            if (e.ck_a) chk("a_imm", bus.A_IMM, e.a);
            if (e.ck_b) chk("b_imm", bus.B_IMM, e.b);
            if (e.is_wb) chk("wb_gap", idle_run, LAT);
            else         chk("issue_lat", cyc - last_acc, 1);
            req_next = e.to_fetch;
          end
          idle_run = 0;
        end else begin
          idle_run++;
        end
        // fetch responder; I_VALID is also raised while I_REQ is low
        v = ($urandom_range(0, 2) != 0);
        bus.I_VALID = v;
        if (bus.I_REQ && v) begin
          if (imem.exists(int'(bus.I_ADDR))) bus.I_DATA = imem[int'(bus.I_ADDR)];
          else                               bus.I_DATA = 32'hC000_0000;
          if (addr_q.size() == 0) chk("unexpected_fetch", 1, 0);
          else                    chk("fetch_addr", bus.I_ADDR, addr_q.pop_front());
          last_acc = cyc;
        end else begin
          bus.I_DATA = $urandom;
        end
        pend_wait = bus.I_REQ && !v;
        pend_addr = bus.I_ADDR;
        // START pulses while busy must be ignored
        if (BUSY)    START = ($urandom_range(0, 7) == 0);
        else if (go) begin START = 1'b1; go = 1'b0; end
        else         START = 1'b0;
      end
    end
  end

  initial begin : p_main
    bit ok;
    int bad;
    bus.I_VALID  = 1'b0;  bus.I_DATA  = '0;
    bus2.I_VALID = 1'b0;  bus2.I_DATA = '0;

    // reset state
    repeat (2) @(negedge CLK);
    chk("init_ctl", {bus.I_REQ, bus.I_ADDR, bus.SEL, bus.X, bus.Y, bus.R_W,
                     bus.W_INST, bus.R_INST, BUSY, HALTED}, 0);
    chk("init_osd", bus.OSD, 0);
    chk("init_imm", {bus.A_IMM, bus.B_IMM}, 0);
    chk("init_addr", bus.ADDR, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_no_req", {bus.I_REQ, BUSY}, 0);

    // random program segments, each resumed from HALT
    gen_pc = 16'h0000;
    mon_en = 1'b1;
    for (int s = 0; s < 6; s++) begin
      gen_segment($urandom_range(8, 16));
      go = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge CLK);
        if (!go) begin ok = 1'b1; break; end
      end
      if (!ok) chk("start_timeout", 0, 1);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge CLK);
        if (HALTED) begin ok = 1'b1; break; end
      end
      if (!ok) chk("halt_timeout", 0, 1);
      chk("halted", HALTED, 1);
      chk("busy_in_halt", BUSY, 0);
      chk("req_in_halt", bus.I_REQ, 0);
      chk("records_left", exp_q.size(), 0);
      chk("fetches_left", addr_q.size(), 0);
    end
    mon_en = 1'b0;

    // asynchronous reset while waiting for an extension word
    @(negedge CLK);
    START = 1'b1; bus.I_VALID = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    chk("p3_fetch_req", bus.I_REQ, 1);
    bus.I_VALID = 1'b1;
    bus.I_DATA  = {2'b00, 4'h3, 2'd3, 6'd4, 6'd5, 6'd6, 5'd0, 1'b1};
    @(negedge CLK);
    bus.I_VALID = 1'b0;
    chk("p3_ext1_req", bus.I_REQ, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_ireq", bus.I_REQ, 0);
    chk("rst_iaddr", bus.I_ADDR, 0);
    chk("rst_osd", bus.OSD, 0);
    chk("rst_imm", {bus.A_IMM, bus.B_IMM}, 0);
    chk("rst_misc", {bus.SEL, bus.X, bus.Y, bus.R_W, bus.W_INST, bus.R_INST, BUSY, HALTED}, 0);
    chk("rst_addr", bus.ADDR, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      bus.I_VALID = 1'b1;
      bus.I_DATA  = $urandom;
      @(negedge CLK);
      if (bus.I_REQ || BUSY) bad++;
    end
    chk("no_req_after_rst", bad, 0);
    bus.I_VALID = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("restart_req", bus.I_REQ, 1);
    chk("restart_pc", bus.I_ADDR, 0);

    // PC wrap across an extension word on the second instance
    @(negedge CLK);
    START2 = 1'b1;
    @(negedge CLK);
    START2 = 1'b0;
    chk("wrap_req", bus2.I_REQ, 1);
    chk("wrap_fetch_addr", bus2.I_ADDR, 16'hFFFF);
    bus2.I_VALID = 1'b1;
    bus2.I_DATA  = {2'b00, 4'h5, 2'd1, 6'd1, 6'd2, 6'd3, 5'd0, 1'b1};
    @(negedge CLK);
    chk("wrap_ext_req", bus2.I_REQ, 1);
    chk("wrap_ext_addr", bus2.I_ADDR, 16'h0000);
    bus2.I_DATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    bus2.I_VALID = 1'b0;
    chk("wrap_sel", bus2.SEL, 1);
    chk("wrap_bimm", bus2.B_IMM, 32'hDEAD_BEEF);
    chk("wrap_osd", bus2.OSD, {4'h5, 6'd1, 6'd2, 6'd3});
    chk("wrap_winst", bus2.W_INST, 6'h01);
    @(negedge CLK);
    chk("wrap_next_req", bus2.I_REQ, 1);
    chk("wrap_next_addr", bus2.I_ADDR, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
